neighbor_info_fetch_pipe: RTL and testbench

Parametrised, pipelined successor to the neighbor-info memory controller. Pops node-ID requests from the bus-side request FIFO, issues one read per cycle to a banked neighbor-info SRAM, and writes `{addr, PE_tag}` results into the Neighbor-ID FIFO. Bank and row are selected by the replay iteration. Iteration changes are handled by a drain-and-switch state machine, so no read ever mixes iterations.

---
 rtl/neighbor_info_fetch_pipe_if.sv | 32 +++
 rtl/neighbor_info_fetch_pipe.sv | 152 +++++++++++++++
 tb/tb_neighbor_info_fetch_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_info_fetch_pipe_if.sv
// Bus bundle for neighbor_info_fetch_pipe: request FIFO pop side, banked SRAM
// port and Neighbor-ID FIFO push side. master = fetch pipe, slave = surroundings.
interface neighbor_info_fetch_pipe_if #(
   parameter int NUM_BANKS = 2,
   parameter int NODE_ID_W = 8,
   parameter int PE_TAG_W  = 2,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 9
);
   logic                                req_empty;
   logic [NODE_ID_W-1:0]                req_node_id;
   logic [PE_TAG_W-1:0]                 req_pe_tag;
   logic                                req_rinc;
   logic [NUM_BANKS-1:0][ADDR_W-1:0]    sram_a;
   logic [NUM_BANKS-1:0]                sram_cen;
   logic [NUM_BANKS-1:0]                sram_wen;
   logic [NUM_BANKS-1:0][DATA_W-1:0]    sram_q;
   logic                                out_full;
   logic                                out_winc;
   logic [DATA_W-1:0]                   out_addr;
   logic [PE_TAG_W-1:0]                 out_pe_tag;

   modport master (
      input  req_empty, req_node_id, req_pe_tag, sram_q, out_full,
      output req_rinc, sram_a, sram_cen, sram_wen, out_winc, out_addr, out_pe_tag
   );

   modport slave (
      output req_empty, req_node_id, req_pe_tag, sram_q, out_full,
      input  req_rinc, sram_a, sram_cen, sram_wen, out_winc, out_addr, out_pe_tag
   );
endinterface

// File: rtl/neighbor_info_fetch_pipe.sv
// Pipelined neighbor-info fetch: one banked SRAM read per cycle, results buffered
// in order. Optional counters stat_reads/stat_stalls under NEIGHBOR_FETCH_STATS_EN.
//
// state  | meaning
// IDLE   | stopped, waiting for enable
// ACTIVE | issuing reads for cur_iter
// DRAIN  | no issue; waiting for in-flight read and buffer to empty
module neighbor_info_fetch_pipe #(
   parameter int NUM_BANKS = 2,
   parameter int ITER_W    = 2,
   parameter int NODE_ID_W = 8,
   parameter int PE_TAG_W  = 2,
   parameter int DATA_W    = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [ITER_W-1:0]      replay_iter,
   neighbor_info_fetch_pipe_if.master bus,
   output logic                   busy
`ifdef NEIGHBOR_FETCH_STATS_EN
   ,
   output logic [15:0]            stat_reads,
   output logic [15:0]            stat_stalls
`endif
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = ITER_W - BANK_W;
   localparam int ADDR_W = ROW_W + NODE_ID_W;
   localparam int PTR_W  = $clog2(OUT_DEPTH);
   localparam int OCC_W  = $clog2(OUT_DEPTH + 1);
   localparam logic [OCC_W:0] DEPTH_C = (OCC_W+1)'(OUT_DEPTH);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t                         state, state_nxt;
   logic [ITER_W-1:0]              cur_iter;
   logic                           latch_iter;
   logic                           inflight;
   logic [BANK_W-1:0]              inflight_bank;
   logic [PE_TAG_W-1:0]            inflight_tag;
   logic [DATA_W+PE_TAG_W-1:0]     buf_mem [OUT_DEPTH];
   logic [PTR_W-1:0]               wr_ptr, rd_ptr;
   logic [OCC_W-1:0]               occ;
   logic                           issue, pop, pipe_empty, iter_ok, room;
   logic [BANK_W-1:0]              issue_bank;
   logic [ROW_W-1:0]               issue_row;
   logic [NUM_BANKS-1:0][ADDR_W-1:0] sram_a_d;
   logic [NUM_BANKS-1:0]           sram_cen_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign issue_bank = cur_iter[ITER_W-1:ROW_W];
   assign issue_row  = cur_iter[ROW_W-1:0];
   // Room counts the in-flight read so a capture always has a free slot.
   assign room       = ({1'b0, occ} + (OCC_W+1)'(inflight)) < DEPTH_C;
   assign iter_ok    = enable && (replay_iter == cur_iter);
   assign issue      = (state == ACTIVE) && iter_ok && !bus.req_empty && room;
   assign pop        = (occ != '0) && !bus.out_full;
   assign pipe_empty = !inflight && (occ == '0);

   always_comb begin
      state_nxt  = state;
      latch_iter = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt  = ACTIVE;
               latch_iter = 1'b1;
            end
         end
         ACTIVE: begin
            if (!iter_ok) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pipe_empty) begin
               if (enable) begin
                  state_nxt  = ACTIVE;
                  latch_iter = 1'b1;
               end else begin
                  state_nxt  = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cur_iter      <= '0;
         inflight      <= 1'b0;
         inflight_bank <= '0;
         inflight_tag  <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         occ           <= '0;
      end else begin
         state    <= state_nxt;
         if (latch_iter) cur_iter <= replay_iter;
         inflight <= issue;
         if (issue) begin
            inflight_bank <= issue_bank;
            inflight_tag  <= bus.req_pe_tag;
         end
         if (inflight) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)      rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + OCC_W'(inflight) - OCC_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (inflight && !reset) buf_mem[wr_ptr] <= {bus.sram_q[inflight_bank], inflight_tag};
   end

   always_comb begin
      sram_a_d   = '0;
      sram_cen_d = '1;
      if (issue) begin
         sram_a_d[issue_bank]   = {issue_row, bus.req_node_id};
         sram_cen_d[issue_bank] = 1'b0;
      end
   end

   assign bus.sram_a   = sram_a_d;
   assign bus.sram_cen = sram_cen_d;
   assign bus.sram_wen = '1;
   assign bus.req_rinc = issue;
   assign bus.out_winc = pop;
   // Head is masked when empty so stale buffer words never reach the outputs.
   assign {bus.out_addr, bus.out_pe_tag} = (occ != '0) ? buf_mem[rd_ptr] : '0;
   assign busy = !pipe_empty;

`ifdef NEIGHBOR_FETCH_STATS_EN
   logic stall;
   assign stall = (state == ACTIVE) && !bus.req_empty && !issue;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_reads  <= '0;
         stat_stalls <= '0;
      end else begin
         if (issue && (stat_reads != 16'hFFFF))  stat_reads  <= stat_reads + 16'd1;
         if (stall && (stat_stalls != 16'hFFFF)) stat_stalls <= stat_stalls + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_neighbor_info_fetch_pipe.sv
// Directed bench for neighbor_info_fetch_pipe: FWFT request queue and SRAM models,
// issue/result logs sampled on the falling edge, per-scenario inline checks.
module tb_neighbor_info_fetch_pipe;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] replay_iter = 2'b00;
   logic       busy;
`ifdef NEIGHBOR_FETCH_STATS_EN
   logic [15:0] stat_reads, stat_stalls;
`endif

   neighbor_info_fetch_pipe_if #(.NUM_BANKS(2), .NODE_ID_W(8), .PE_TAG_W(2),
                                 .DATA_W(16), .ADDR_W(9)) bus ();

   neighbor_info_fetch_pipe #(.NUM_BANKS(2), .ITER_W(2), .NODE_ID_W(8), .PE_TAG_W(2),
                              .DATA_W(16), .OUT_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .replay_iter (replay_iter),
      .bus         (bus),
      .busy        (busy)
`ifdef NEIGHBOR_FETCH_STATS_EN
      ,
      .stat_reads  (stat_reads),
      .stat_stalls (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // FWFT request FIFO model
   logic [7:0] rq_node [64];
   logic [1:0] rq_tag  [64];
   int         rq_wr = 0;
   int         rq_rd = 0;
   assign bus.req_empty   = (rq_rd == rq_wr);
   assign bus.req_node_id = rq_node[rq_rd[5:0]];
   assign bus.req_pe_tag  = rq_tag[rq_rd[5:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset)             rq_rd <= rq_wr;
      else if (bus.req_rinc) rq_rd <= rq_rd + 1;
   end

   // SRAM word = 0x8000 | bank<<12 | address
   always @(posedge clk) begin
      for (int b = 0; b < 2; b++)
         if (!bus.sram_cen[b]) bus.sram_q[b] <= 16'h8000 | 16'(b << 12) | 16'(bus.sram_a[b]);
   end

   int          iss_n = 0, out_n = 0;
   int          iss_cyc [64];
   logic [1:0]  iss_cen [64];
   logic [17:0] iss_a   [64];
   int          out_cyc [64];
   logic [15:0] out_ad  [64];
   logic [1:0]  out_tg  [64];

   always @(negedge clk) begin
      if (bus.req_rinc) begin
         iss_cyc[iss_n] <= cyc;
         iss_cen[iss_n] <= bus.sram_cen;
         iss_a[iss_n]   <= bus.sram_a;
         iss_n          <= iss_n + 1;
      end
      if (bus.out_winc) begin
         out_cyc[out_n] <= cyc;
         out_ad[out_n]  <= bus.out_addr;
         out_tg[out_n]  <= bus.out_pe_tag;
         out_n          <= out_n + 1;
      end
   end

   localparam logic [42:0] RST_VEC = {3'b000, 2'b11, 2'b11, 18'h0, 16'h0, 2'b00};

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] n, input logic [1:0] t);
      rq_node[rq_wr[5:0]] = n;
      rq_tag[rq_wr[5:0]]  = t;
      rq_wr++;
   endtask

   task automatic test_reset;
      logic [42:0] got;
      reset = 1'b1;
      enable = 1'b0;
      bus.out_full = 1'b0;
      tick(3);
      got = {bus.req_rinc, bus.out_winc, busy, bus.sram_cen, bus.sram_wen,
             bus.sram_a, bus.out_addr, bus.out_pe_tag};
      n_cmp++;
      if (got !== RST_VEC) begin
         n_err++;
         $display("FAIL reset_values: got %h want %h", got, RST_VEC);
      end
      reset = 1'b0;
      tick(2);
      n_cmp++;
      if ({busy, bus.req_rinc, bus.sram_cen} !== 4'b0011) begin
         n_err++;
         $display("FAIL idle_after_reset: got %b want %b", {busy, bus.req_rinc, bus.sram_cen}, 4'b0011);
      end
   endtask

   task automatic test_basic;
      int ib = iss_n, ob = out_n;
      replay_iter = 2'b10;
      enable = 1'b1;
      push(8'd5, 2'd1); push(8'd6, 2'd2); push(8'd7, 2'd3);
      for (int k = 0; k < 40 && out_n < ob + 3; k++) tick(1);
      n_cmp++;
      if (out_n != ob + 3) begin
         n_err++;
         $display("FAIL basic_count: got %0d want %0d", out_n - ob, 3);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (iss_cen[ib+i] !== 2'b01) begin
            n_err++; $display("FAIL basic_cen[%0d]: got %b want %b", i, iss_cen[ib+i], 2'b01);
         end
         n_cmp++;
         if (iss_a[ib+i] !== {9'(5 + i), 9'h000}) begin
            n_err++; $display("FAIL basic_sram_a[%0d]: got %h want %h", i, iss_a[ib+i], {9'(5 + i), 9'h000});
         end
         n_cmp++;
         if (out_ad[ob+i] !== 16'(16'h9005 + i)) begin
            n_err++; $display("FAIL basic_addr[%0d]: got %h want %h", i, out_ad[ob+i], 16'(16'h9005 + i));
         end
         n_cmp++;
         if (out_tg[ob+i] !== 2'(1 + i)) begin
            n_err++; $display("FAIL basic_tag[%0d]: got %0d want %0d", i, out_tg[ob+i], 1 + i);
         end
         n_cmp++;
         if (out_cyc[ob+i] - iss_cyc[ib+i] != 2) begin
            n_err++; $display("FAIL basic_latency[%0d]: got %0d want 2", i, out_cyc[ob+i] - iss_cyc[ib+i]);
         end
         if (i > 0) begin
            n_cmp++;
            if (iss_cyc[ib+i] - iss_cyc[ib+i-1] != 1) begin
               n_err++; $display("FAIL basic_back_to_back[%0d]: got gap %0d want 1", i, iss_cyc[ib+i] - iss_cyc[ib+i-1]);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int ib = iss_n, ob = out_n;
      bus.out_full = 1'b1;
      for (int i = 0; i < 10; i++) push(8'(8'h10 + i), 2'(i));
      tick(20);
      n_cmp++;
      if ({iss_n - ib, out_n - ob} != {32'd4, 32'd0} || busy !== 1'b1) begin
         n_err++;
         $display("FAIL bp_stall: got pops %0d outs %0d busy %b want pops 4 outs 0 busy 1", iss_n - ib, out_n - ob, busy);
      end
      bus.out_full = 1'b0;
      for (int k = 0; k < 100 && out_n < ob + 10; k++) tick(1);
      n_cmp++;
      if (out_n - ob != 10 || iss_n - ib != 10) begin
         n_err++;
         $display("FAIL bp_count: got outs %0d pops %0d want 10 10", out_n - ob, iss_n - ib);
      end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if ({out_ad[ob+i], out_tg[ob+i]} !== {16'(16'h9010 + i), 2'(i)}) begin
            n_err++;
            $display("FAIL bp_result[%0d]: got %h/%0d want %h/%0d", i, out_ad[ob+i], out_tg[ob+i], 16'(16'h9010 + i), i % 4);
         end
      end
   endtask

   task automatic test_iter_change;
      int ib, ob, chg;
      replay_iter = 2'b01;
      tick(6);
      ib = iss_n; ob = out_n;
      for (int i = 0; i < 6; i++) push(8'(8'h20 + i), 2'(i));
      for (int k = 0; k < 20 && iss_n < ib + 2; k++) tick(1);
      replay_iter = 2'b11;
      chg = cyc;
      for (int k = 0; k < 60 && out_n < ob + 6; k++) tick(1);
      n_cmp++;
      if (out_n - ob != 6) begin
         n_err++; $display("FAIL iter_count: got %0d want 6", out_n - ob);
      end
      n_cmp++;
      if (!(iss_cyc[ib+1] < chg && iss_cyc[ib+2] > chg)) begin
         n_err++; $display("FAIL iter_split: got issue cycles %0d,%0d around change %0d", iss_cyc[ib+1], iss_cyc[ib+2], chg);
      end
      n_cmp++;
      if (iss_cyc[ib+2] != out_cyc[ob+1] + 2) begin
         n_err++; $display("FAIL iter_drain_first: got %0d want %0d", iss_cyc[ib+2], out_cyc[ob+1] + 2);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (i < 2) begin
            if ({iss_cen[ib+i], iss_a[ib+i], out_ad[ob+i]} !== {2'b10, 9'h000, 9'(9'h120 + i), 16'(16'h8120 + i)}) begin
               n_err++; $display("FAIL iter_old[%0d]: got cen %b a %h q %h", i, iss_cen[ib+i], iss_a[ib+i], out_ad[ob+i]);
            end
         end else begin
            if ({iss_cen[ib+i], iss_a[ib+i], out_ad[ob+i]} !== {2'b01, 9'(9'h120 + i), 9'h000, 16'(16'h9120 + i)}) begin
               n_err++; $display("FAIL iter_new[%0d]: got cen %b a %h q %h", i, iss_cen[ib+i], iss_a[ib+i], out_ad[ob+i]);
            end
         end
         n_cmp++;
         if (out_tg[ob+i] !== 2'(i)) begin
            n_err++; $display("FAIL iter_tag[%0d]: got %0d want %0d", i, out_tg[ob+i], i % 4);
         end
      end
   endtask

   task automatic test_enable_drop;
      int ib = iss_n, ob = out_n;
      for (int i = 0; i < 6; i++) push(8'(8'h30 + i), 2'(i));
      for (int k = 0; k < 20 && iss_n < ib + 3; k++) tick(1);
      enable = 1'b0;
      for (int k = 0; k < 40 && (out_n < ob + 3 || busy); k++) tick(1);
      n_cmp++;
      if (out_n - ob != 3 || busy !== 1'b0) begin
         n_err++; $display("FAIL drop_drain: got outs %0d busy %b want 3 0", out_n - ob, busy);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({out_ad[ob+i], out_tg[ob+i]} !== {16'(16'h9130 + i), 2'(i)}) begin
            n_err++; $display("FAIL drop_result[%0d]: got %h/%0d want %h/%0d", i, out_ad[ob+i], out_tg[ob+i], 16'(16'h9130 + i), i);
         end
      end
      tick(10);
      n_cmp++;
      if (iss_n - ib != 3 || busy !== 1'b0) begin
         n_err++; $display("FAIL drop_idle: got pops %0d busy %b want 3 0", iss_n - ib, busy);
      end
   endtask

   task automatic test_reset_mid;
      int ib = iss_n, ob = out_n;
      logic [42:0] got;
      bus.out_full = 1'b1;
      enable = 1'b1;
      for (int k = 0; k < 20 && iss_n < ib + 3; k++) tick(1);
      n_cmp++;
      if (iss_n - ib != 3) begin
         n_err++; $display("FAIL rst_setup: got pops %0d want 3", iss_n - ib);
      end
      reset = 1'b1;
      enable = 1'b0;
      tick(1);
      got = {bus.req_rinc, bus.out_winc, busy, bus.sram_cen, bus.sram_wen,
             bus.sram_a, bus.out_addr, bus.out_pe_tag};
      n_cmp++;
      if (got !== RST_VEC) begin
         n_err++; $display("FAIL rst_mid_values: got %h want %h", got, RST_VEC);
      end
      reset = 1'b0;
      bus.out_full = 1'b0;
      tick(10);
      n_cmp++;
      if (out_n != ob || iss_n - ib != 3 || busy !== 1'b0) begin
         n_err++; $display("FAIL rst_discard: got outs %0d pops %0d busy %b want 0 3 0", out_n - ob, iss_n - ib, busy);
      end
   endtask

   task automatic test_stats;
      int ib = iss_n, ob = out_n;
      replay_iter = 2'b10;
      bus.out_full = 1'b1;
      for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 2'(i));
      enable = 1'b1;
      for (int k = 0; k < 20 && iss_n < ib + 4; k++) tick(1);
      tick(1);
      enable = 1'b0;
      bus.out_full = 1'b0;
      for (int k = 0; k < 40 && (out_n < ob + 4 || busy); k++) tick(1);
      n_cmp++;
      if (out_n - ob != 4 || iss_n - ib != 4) begin
         n_err++; $display("FAIL stats_counts: got outs %0d pops %0d want 4 4", out_n - ob, iss_n - ib);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({out_ad[ob+i], out_tg[ob+i]} !== {16'(16'h9040 + i), 2'(i)}) begin
            n_err++; $display("FAIL stats_result[%0d]: got %h/%0d want %h/%0d", i, out_ad[ob+i], out_tg[ob+i], 16'(16'h9040 + i), i);
         end
      end
`ifdef NEIGHBOR_FETCH_STATS_EN
      n_cmp++;
      if (stat_reads !== 16'd4) begin
         n_err++; $display("FAIL stat_reads: got %0d want 4", stat_reads);
      end
      n_cmp++;
      if (stat_stalls !== 16'd2) begin
         n_err++; $display("FAIL stat_stalls: got %0d want 2", stat_stalls);
      end
`endif
   endtask

   task automatic test_recovery;
      int ib = iss_n, ob = out_n;
      enable = 1'b1;
      for (int k = 0; k < 20 && out_n < ob + 1; k++) tick(1);
      n_cmp++;
      if (out_n - ob != 1 || iss_n - ib != 1) begin
         n_err++; $display("FAIL recov_count: got outs %0d pops %0d want 1 1", out_n - ob, iss_n - ib);
      end
      n_cmp++;
      if ({iss_a[ib], out_ad[ob], out_tg[ob]} !== {9'h044, 9'h000, 16'h9044, 2'd0}) begin
         n_err++; $display("FAIL recov_result: got a %h q %h tag %0d want a %h q 9044 tag 0", iss_a[ib], out_ad[ob], out_tg[ob], {9'h044, 9'h000});
      end
`ifdef NEIGHBOR_FETCH_STATS_EN
      n_cmp++;
      if (stat_reads !== 16'd5) begin
         n_err++; $display("FAIL recov_stat_reads: got %0d want 5", stat_reads);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_iter_change();
      test_enable_drop();
      test_reset_mid();
      test_stats();
      test_recovery();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
